fifo_rd_stream: RTL and testbench



---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_skid_buf.sv | 78 +++++++
 rtl/fifo_rd_stream.sv | 123 ++++++++++++
 tb/tb_fifo_rd_stream.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO and its stream-side readers.
//   FIFO_WIDTH     - default data width of the FIFO word
//   rd_state_t     - read-side controller states
//   stream_word_t  - one stream beat: data plus end-of-frame marker
//   ptr_inc        - modulo-3 pointer increment for the 3-entry skid buffer
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } rd_state_t;

    typedef struct packed {
        logic                  last;
        logic [FIFO_WIDTH-1:0] data;
    } stream_word_t;

    // Pointers of the 3-deep buffer walk 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// ---------------------------------------------------------------------------
// fifo_skid_buf
// Three-entry first-in first-out holding buffer that decouples the FIFO read
// latency from stream backpressure.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push         - write push_word at the tail this cycle
//   push_word    - word to store
//   pop          - remove the head word this cycle (ignored when empty)
//   head         - current head word, forced to zero while empty
//   occ          - number of stored words, 0..3
// ---------------------------------------------------------------------------
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_word,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [3];
    logic [1:0]   rd_ptr_reg;
    logic [1:0]   wr_ptr_reg;
    logic [1:0]   occ_reg;
    logic [1:0]   occ_next;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (occ_reg != 2'd0);
    // A push into a full buffer is only legal when a pop frees a slot the
    // same cycle; the issue logic upstream never lets it happen otherwise.
    assign do_push = push && ((occ_reg != 2'd3) || do_pop);

    always_comb begin
        occ_next = occ_reg;
        unique case ({do_push, do_pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= 2'd0;
            wr_ptr_reg <= 2'd0;
            occ_reg    <= 2'd0;
        end else begin
            occ_reg <= occ_next;
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
        end
    end

    // Storage needs no reset: contents are only visible through head, which
    // is masked while the buffer is empty.
    for (genvar gi = 0; gi < 3; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == 2'(gi))) begin
                mem[gi] <= push_word;
            end
        end
    end

    assign head = (occ_reg != 2'd0) ? mem[rd_ptr_reg] : '0;
    assign occ  = occ_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Reads words from the synchronous FIFO and presents them as a valid/ready
// stream framed into bursts of BURST_LEN words (m_last on the final word).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   enable          - level, permits new FIFO reads
//   fifo_empty      - FIFO empty flag
//   fifo_underflow  - FIFO underflow flag (latched into underflow_err)
//   fifo_data_out   - FIFO read data, valid the cycle after an accepted read
//   fifo_rd_en      - FIFO read request
//   m_data/m_valid/m_last/m_ready - output stream
//   word_cnt        - index of the next word to read within the frame
//   frame_cnt       - count of frames whose last beat was handshaken
//   underflow_err   - sticky underflow indicator
//   busy            - buffered or in-flight data exists
// ---------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter  int BURST_LEN  = 8,
    localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [CNT_W-1:0]      word_cnt,
    output logic [15:0]           frame_cnt,
    output logic                  underflow_err,
    output logic                  busy
);

    rd_state_t              state_reg;
    rd_state_t              state_next;
    logic                   inflight_reg;
    logic                   inflight_last_reg;
    logic [CNT_W-1:0]       word_cnt_reg;
    logic [15:0]            frame_cnt_reg;
    logic                   underflow_err_reg;

    logic [1:0]             occ;
    logic [FIFO_WIDTH:0]    head;
    logic [2:0]             pending;
    logic                   tag_last;
    logic                   pop;

    fifo_skid_buf #(
        .W (FIFO_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_reg),
        .push_word ({inflight_last_reg, fifo_data_out}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign m_valid = (occ != 2'd0);
    assign m_last  = head[FIFO_WIDTH];
    assign m_data  = head[FIFO_WIDTH-1:0];
    assign pop     = m_valid && m_ready;
    assign busy    = (occ != 2'd0) || inflight_reg;

    // Count in-flight reads against buffer space so every read that returns
    // has a slot; m_ready deliberately plays no part here.
    assign pending    = {1'b0, occ} + {2'b00, inflight_reg};
    assign tag_last   = (word_cnt_reg == CNT_W'(BURST_LEN - 1));
    assign fifo_rd_en = enable && !fifo_empty && (pending < 3'd3) && (state_reg == RUN);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (!enable) state_next = busy ? FLUSH : IDLE;
            FLUSH: begin
                if (enable)     state_next = RUN;
                else if (!busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            word_cnt_reg      <= '0;
            frame_cnt_reg     <= 16'd0;
            underflow_err_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            inflight_reg      <= fifo_rd_en;
            // The last tag travels with the read so it lines up with the
            // data word returned one cycle later.
            inflight_last_reg <= fifo_rd_en && tag_last;
            if (fifo_rd_en) begin
                word_cnt_reg <= tag_last ? '0 : word_cnt_reg + 1'b1;
            end
            if (pop && m_last) begin
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (fifo_underflow) begin
                underflow_err_reg <= 1'b1;
            end
        end
    end

    assign word_cnt      = word_cnt_reg;
    assign frame_cnt     = frame_cnt_reg;
    assign underflow_err = underflow_err_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic        fifo_underflow = 1'b0;
    logic [15:0] fifo_data_out = 16'h0;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic [2:0]  word_cnt;
    logic [15:0] frame_cnt;
    logic        underflow_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.FIFO_WIDTH(16), .BURST_LEN(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data_out  (fifo_data_out),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .word_cnt       (word_cnt),
        .frame_cnt      (frame_cnt),
        .underflow_err  (underflow_err),
        .busy           (busy)
    );

    // Behavioural FIFO with one-cycle registered read.
    logic [15:0] fmem [0:255];
    int          wp = 0;
    int          rp = 0;
    logic        fifo_flush = 1'b0;
    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rp <= wp;
        end else if (fifo_rd_en && (wp != rp)) begin
            fifo_data_out <= fmem[rp % 256];
            rp <= rp + 1;
        end
    end

    task automatic fifo_push(input logic [15:0] v);
        fmem[wp % 256] = v;
        wp = wp + 1;
    endtask

    // Monitor: samples at the falling edge, records handshakes and read issue.
    int          cyc = 0;
    logic [15:0] obs_data [$];
    logic        obs_last [$];
    int          obs_cyc  [$];
    int          rd_cnt = 0;
    int          first_rd = -1;
    int          first_vld = -1;
    logic        mon_clr = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            obs_data.delete();
            obs_last.delete();
            obs_cyc.delete();
            rd_cnt = 0;
            first_rd = -1;
            first_vld = -1;
        end else begin
            if (fifo_rd_en) begin
                rd_cnt = rd_cnt + 1;
                if (first_rd < 0) first_rd = cyc;
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (m_valid && m_ready) begin
                obs_data.push_back(m_data);
                obs_last.push_back(m_last);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        m_ready = 1'b0;
        fifo_underflow = 1'b0;
        fifo_flush = 1'b1;
        mon_clr = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        fifo_flush = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (obs_data.size() >= n) break;
            step();
        end
        ok = (obs_data.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_last, busy, underflow_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {fifo_rd_en, m_valid, m_last, busy, underflow_err});
        end
        checks++;
        if (m_data !== 16'h0) begin errors++; $display("FAIL reset_mdata: got %h expected 0000", m_data); end
        checks++;
        if (word_cnt !== 3'd0) begin errors++; $display("FAIL reset_wordcnt: got %0d expected 0", word_cnt); end
        checks++;
        if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_framecnt: got %0d expected 0", frame_cnt); end

        // Build up occ=2, inflight=1 mid-frame, then reset asynchronously.
        do_reset();
        for (int i = 1; i <= 8; i++) fifo_push(16'(i));
        enable = 1'b1;
        repeat (4) step();
        checks++;
        if ({m_valid, busy, word_cnt} !== {1'b1, 1'b1, 3'd3}) begin
            errors++;
            $display("FAIL midframe_setup: got valid=%b busy=%b wcnt=%0d expected 1 1 3", m_valid, busy, word_cnt);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, busy, fifo_rd_en, m_last} !== 4'b0) begin
            errors++;
            $display("FAIL async_reset_flags: got %b expected 0000", {m_valid, busy, fifo_rd_en, m_last});
        end
        checks++;
        if ({m_data, word_cnt} !== 19'h0) begin
            errors++;
            $display("FAIL async_reset_data: got data=%h wcnt=%0d expected 0000 0", m_data, word_cnt);
        end
        do_reset();
        repeat (5) step();
        checks++;
        if (first_vld !== -1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got first_vld=%0d valid=%b expected -1 0", first_vld, m_valid);
        end
        fifo_push(16'h00AA);
        m_ready = 1'b1;
        enable = 1'b1;
        wait_beats(1, 20, ok);
        checks++;
        if (!ok || obs_data[0] !== 16'h00AA || obs_last[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first: got ok=%b data=%h expected 1 00aa", ok, ok ? obs_data[0] : 16'hx);
        end
    endtask

    task automatic test_stream();
        bit ok;
        do_reset();
        for (int i = 1; i <= 16; i++) fifo_push(16'(i));
        m_ready = 1'b1;
        enable = 1'b1;
        wait_beats(16, 60, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_count: got %0d expected 16", obs_data.size()); end
        checks++;
        if (first_vld - first_rd !== 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d expected 2", first_vld - first_rd);
        end
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_data[i] !== 16'(i + 1) || obs_last[i] !== (i == 7 || i == 15)) begin
                    errors++;
                    $display("FAIL stream_beat%0d: got %h/%b expected %h/%b", i, obs_data[i], obs_last[i], 16'(i + 1), (i == 7 || i == 15));
                end
            end
            checks++;
            if (obs_cyc[15] - obs_cyc[0] !== 15) begin
                errors++;
                $display("FAIL stream_b2b: got span %0d expected 15", obs_cyc[15] - obs_cyc[0]);
            end
        end
        step();
        checks++;
        if (frame_cnt !== 16'd2 || word_cnt !== 3'd0) begin
            errors++;
            $display("FAIL stream_counts: got fcnt=%0d wcnt=%0d expected 2 0", frame_cnt, word_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit stable;
        logic [15:0] hold;
        do_reset();
        for (int i = 1; i <= 16; i++) fifo_push(16'(i));
        m_ready = 1'b1;
        enable = 1'b1;
        wait_beats(3, 30, ok);
        m_ready = 1'b0;
        hold = m_data;
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (m_data !== hold || m_valid !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_hold: got %h expected %h", m_data, hold); end
        checks++;
        if (fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_rden: got rd_en=%b busy=%b expected 0 1", fifo_rd_en, busy);
        end
        checks++;
        if (rd_cnt !== obs_data.size() + 3) begin
            errors++;
            $display("FAIL bp_outstanding: got %0d expected %0d", rd_cnt, obs_data.size() + 3);
        end
        m_ready = 1'b1;
        wait_beats(16, 60, ok);
        checks++;
        if (!ok || obs_data.size() !== 16) begin errors++; $display("FAIL bp_count: got %0d expected 16", obs_data.size()); end
        if (ok) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (obs_data[i] !== 16'(i + 1) || obs_last[i] !== (i == 7 || i == 15)) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", i, obs_data[i], obs_last[i], 16'(i + 1), (i == 7 || i == 15));
                end
            end
        end
    endtask

    task automatic test_partial();
        bit ok;
        bit any_last;
        do_reset();
        for (int i = 1; i <= 3; i++) fifo_push(16'(i));
        m_ready = 1'b1;
        enable = 1'b1;
        repeat (10) step();
        any_last = 1'b0;
        foreach (obs_last[i]) if (obs_last[i] !== 1'b0) any_last = 1'b1;
        checks++;
        if (obs_data.size() !== 3 || any_last) begin
            errors++;
            $display("FAIL partial_beats: got %0d last=%b expected 3 0", obs_data.size(), any_last);
        end
        checks++;
        if ({word_cnt, frame_cnt, busy} !== {3'd3, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL partial_state: got wcnt=%0d fcnt=%0d busy=%b expected 3 0 0", word_cnt, frame_cnt, busy);
        end
        for (int i = 4; i <= 8; i++) fifo_push(16'(i));
        wait_beats(8, 30, ok);
        checks++;
        if (!ok || obs_data[7] !== 16'h0008 || obs_last[7] !== 1'b1 || obs_last[6] !== 1'b0) begin
            errors++;
            $display("FAIL partial_last: got ok=%b data=%h last=%b expected 1 0008 1", ok, ok ? obs_data[7] : 16'hx, ok ? obs_last[7] : 1'bx);
        end
        step();
        checks++;
        if (frame_cnt !== 16'd1 || word_cnt !== 3'd0) begin
            errors++;
            $display("FAIL partial_counts: got fcnt=%0d wcnt=%0d expected 1 0", frame_cnt, word_cnt);
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        do_reset();
        for (int i = 1; i <= 16; i++) fifo_push(16'(i));
        enable = 1'b1;
        repeat (4) step();
        checks++;
        if ({m_valid, busy, fifo_rd_en} !== 3'b110 || rd_cnt !== 3) begin
            errors++;
            $display("FAIL drop_setup: got valid=%b busy=%b rd_en=%b reads=%0d expected 1 1 0 3", m_valid, busy, fifo_rd_en, rd_cnt);
        end
        enable = 1'b0;
        m_ready = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL drop_flush: got busy=%b rd_en=%b expected 1 0", busy, fifo_rd_en);
        end
        wait_beats(3, 20, ok);
        repeat (3) step();
        checks++;
        if (obs_data.size() !== 3 || rd_cnt !== 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_drain: got beats=%0d reads=%0d busy=%b expected 3 3 0", obs_data.size(), rd_cnt, busy);
        end
        checks++;
        if (!ok || obs_data[0] !== 16'h1 || obs_data[2] !== 16'h3 || word_cnt !== 3'd3) begin
            errors++;
            $display("FAIL drop_words: got ok=%b wcnt=%0d expected 1 3", ok, word_cnt);
        end
        enable = 1'b1;
        wait_beats(8, 40, ok);
        checks++;
        if (!ok || obs_data[3] !== 16'h4 || obs_data[7] !== 16'h8 || obs_last[7] !== 1'b1 || obs_last[2] !== 1'b0) begin
            errors++;
            $display("FAIL drop_resume: got ok=%b data7=%h last7=%b expected 1 0008 1", ok, ok ? obs_data[7] : 16'hx, ok ? obs_last[7] : 1'bx);
        end
        enable = 1'b0;
        step();
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL drop_framecnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_underflow();
        do_reset();
        checks++;
        if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_initial: got %b expected 0", underflow_err); end
        fifo_underflow = 1'b1;
        step();
        fifo_underflow = 1'b0;
        checks++;
        if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", underflow_err); end
        repeat (5) step();
        checks++;
        if (underflow_err !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", underflow_err); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (underflow_err !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", underflow_err); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_partial();
        test_enable_drop();
        test_underflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
